// File: rtl/ff_bank_pkg.sv
// ============================================================================
//  Module     : ff_bank_pkg
//  Description: Shared mode and SR-collision policy encodings for ff_bank.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package ff_bank_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_SR = 2'b00;
    localparam mode_t MODE_JK = 2'b01;
    localparam mode_t MODE_D  = 2'b10;
    localparam mode_t MODE_T  = 2'b11;

    localparam int POL_HOLD = 0;
    localparam int POL_RST  = 1;
    localparam int POL_SET  = 2;

endpackage : ff_bank_pkg

`default_nettype wire

// File: rtl/ff_cell.sv
// ============================================================================
//  Module     : ff_cell
//  Description: Combinational next-state and S=R=1 detect for one channel.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module ff_cell
    import ff_bank_pkg::*;
#(
    parameter int SR_POLICY = POL_HOLD
) (
    input  logic       q,
    input  logic       a,
    input  logic       b,
    input  logic [1:0] mode,
    output logic       q_nxt,
    output logic       ill
);

    always_comb begin
        q_nxt = q;
        ill   = 1'b0;
        case (mode)
            MODE_SR: begin
                if (a && b) begin
                    ill = 1'b1;
                    case (SR_POLICY)
                        POL_RST: q_nxt = 1'b0;
                        POL_SET: q_nxt = 1'b1;
                        default: q_nxt = q;
                    endcase
                end else if (a) begin
                    q_nxt = 1'b1;
                end else if (b) begin
                    q_nxt = 1'b0;
                end
            end
            MODE_JK: begin
                if (a && b) begin
                    q_nxt = ~q;
                end else if (a) begin
                    q_nxt = 1'b1;
                end else if (b) begin
                    q_nxt = 1'b0;
                end
            end
            MODE_D:  q_nxt = a;
            default: q_nxt = q ^ a;
        endcase
    end

endmodule : ff_cell

`default_nettype wire

// File: rtl/ff_bank.sv
// ============================================================================
//  Module     : ff_bank
//  Description: WIDTH-channel SR/JK/D/T flip-flop bank with load, enable,
//               sticky S=R=1 flags and a saturating illegal-edge counter.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module ff_bank
    import ff_bank_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter int               NEG_EDGE  = 1,
    parameter logic [WIDTH-1:0] INIT      = '0,
    parameter int               SR_POLICY = POL_HOLD,
    parameter int               CNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [2*WIDTH-1:0] mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    input  logic               err_clr,
    output logic [WIDTH-1:0]   q,
    output logic [WIDTH-1:0]   qbar,
    output logic [WIDTH-1:0]   illegal,
    output logic [CNT_W-1:0]   illegal_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] cell_nxt;
    logic [WIDTH-1:0] cell_ill;
    logic [WIDTH-1:0] ev_bits;
    logic             ev_any;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_cell
            ff_cell #(
                .SR_POLICY (SR_POLICY)
            ) u_cell (
                .q     (q_q[i]),
                .a     (a[i]),
                .b     (b[i]),
                .mode  (mode[2*i +: 2]),
                .q_nxt (cell_nxt[i]),
                .ill   (cell_ill[i])
            );
        end
    endgenerate

    always_comb begin
        // A load or a disabled edge never qualifies as an illegal event
        ev_bits = (en && !load) ? cell_ill : '0;
        ev_any  = |ev_bits;

        if (load) begin
            q_d = load_val;
        end else if (en) begin
            q_d = cell_nxt;
        end else begin
            q_d = q_q;
        end

        if (err_clr) begin
            illegal_d = ev_bits;
            cnt_d     = ev_any ? CNT_ONE : '0;
        end else begin
            illegal_d = illegal_q | ev_bits;
            cnt_d     = (ev_any && (cnt_q != CNT_MAX)) ? cnt_q + CNT_ONE : cnt_q;
        end
    end

    generate
        if (NEG_EDGE != 0) begin : g_neg_edge
            always_ff @(negedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_q       <= INIT;
                    illegal_q <= '0;
                    cnt_q     <= '0;
                end else begin
                    q_q       <= q_d;
                    illegal_q <= illegal_d;
                    cnt_q     <= cnt_d;
                end
            end
        end else begin : g_pos_edge
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_q       <= INIT;
                    illegal_q <= '0;
                    cnt_q     <= '0;
                end else begin
                    q_q       <= q_d;
                    illegal_q <= illegal_d;
                    cnt_q     <= cnt_d;
                end
            end
        end
    endgenerate

    assign q           = q_q;
    assign qbar        = ~q_q;
    assign illegal     = illegal_q;
    assign illegal_cnt = cnt_q;

endmodule : ff_bank

`default_nettype wire

// File: tb/tb_ff_bank.sv
// ============================================================================
//  Module     : tb_ff_bank
//  Description: Self-checking bench for ff_bank; two instances differ in INIT
//               and S=R=1 policy, both compared to a behavioural model.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ff_bank;

    localparam int         CMAX  = 3;
    localparam logic [3:0] INIT0 = 4'b0000;
    localparam logic [3:0] INIT1 = 4'b0101;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic       en       = 1'b0;
    logic       load     = 1'b0;
    logic       err_clr  = 1'b0;
    logic [7:0] mode     = '0;
    logic [3:0] a        = '0;
    logic [3:0] b        = '0;
    logic [3:0] load_val = '0;

    logic [3:0] q_o   [2];
    logic [3:0] qb_o  [2];
    logic [3:0] ill_o [2];
    logic [1:0] cnt_o [2];

    logic [3:0] m_q   [2];
    logic [3:0] m_ill [2];
    int         m_cnt [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ff_bank #(.WIDTH(4), .NEG_EDGE(1), .INIT(INIT0), .SR_POLICY(0), .CNT_W(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b),
        .load(load), .load_val(load_val), .err_clr(err_clr),
        .q(q_o[0]), .qbar(qb_o[0]), .illegal(ill_o[0]), .illegal_cnt(cnt_o[0])
    );

    ff_bank #(.WIDTH(4), .NEG_EDGE(1), .INIT(INIT1), .SR_POLICY(1), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b),
        .load(load), .load_val(load_val), .err_clr(err_clr),
        .q(q_o[1]), .qbar(qb_o[1]), .illegal(ill_o[1]), .illegal_cnt(cnt_o[1])
    );

    // Behaviour of one channel from the truth tables; pol selects the S=R=1 outcome
    function automatic logic ref_bit(logic cur, logic [1:0] m, logic s, logic r, int pol);
        if (m == 2'd0) begin
            if (s && r) return (pol == 0) ? cur : (pol == 2);
            return s ? 1'b1 : (r ? 1'b0 : cur);
        end
        if (m == 2'd1) begin
            if (s && r) return ~cur;
            return s ? 1'b1 : (r ? 1'b0 : cur);
        end
        if (m == 2'd2) return s;
        return s ? ~cur : cur;
    endfunction

    task automatic model_reset();
        m_q[0] = INIT0;
        m_q[1] = INIT1;
        for (int k = 0; k < 2; k++) begin
            m_ill[k] = '0;
            m_cnt[k] = 0;
        end
    endtask

    task automatic model_edge();
        if (!rst_n) return;
        for (int k = 0; k < 2; k++) begin
            logic [3:0] nq;
            logic [3:0] ev;
            nq = m_q[k];
            ev = '0;
            for (int i = 0; i < 4; i++) begin
                if (en && !load) begin
                    nq[i] = ref_bit(m_q[k][i], mode[2*i +: 2], a[i], b[i], k);
                    ev[i] = (mode[2*i +: 2] == 2'd0) && a[i] && b[i];
                end
            end
            if (load) nq = load_val;
            m_q[k] = nq;
            if (err_clr) begin
                m_ill[k] = ev;
                m_cnt[k] = (ev != 0) ? 1 : 0;
            end else begin
                m_ill[k] = m_ill[k] | ev;
                if (ev != 0 && m_cnt[k] < CMAX) m_cnt[k] = m_cnt[k] + 1;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            logic [3:0] exp_init;
            exp_init = (k == 0) ? INIT0 : INIT1;
            checks++;
            if (q_o[k] !== exp_init) begin
                errors++; $display("FAIL reset_q dut%0d: got %b want %b", k, q_o[k], exp_init);
            end
            checks++;
            if (qb_o[k] !== ~exp_init) begin
                errors++; $display("FAIL reset_qbar dut%0d: got %b want %b", k, qb_o[k], ~exp_init);
            end
            checks++;
            if (ill_o[k] !== 4'b0000 || cnt_o[k] !== 2'd0) begin
                errors++; $display("FAIL reset_err dut%0d: got ill=%b cnt=%0d want 0000/0", k, ill_o[k], cnt_o[k]);
            end
        end
        en = 1'b1; load = 1'b1; load_val = 4'b1001;
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (q_o[k] !== m_q[k]) begin
                errors++; $display("FAIL reset_hold dut%0d: got %b want %b", k, q_o[k], m_q[k]);
            end
        end
        load = 1'b0; en = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_mixed();
        en = 1'b1; load = 1'b1; load_val = 4'b0000; err_clr = 1'b1;
        tick();
        load = 1'b0; err_clr = 1'b0;
        mode = 8'b11_10_01_00; a = 4'b1111; b = 4'b0010;
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (q_o[k] !== 4'b1111 || q_o[k] !== m_q[k]) begin
                errors++; $display("FAIL mixed_q dut%0d: got %b want 1111", k, q_o[k]);
            end
            checks++;
            if (ill_o[k] !== 4'b0000 || cnt_o[k] !== 2'd0) begin
                errors++; $display("FAIL mixed_err dut%0d: got ill=%b cnt=%0d want 0000/0", k, ill_o[k], cnt_o[k]);
            end
        end
        a = 4'($urandom); b = 4'($urandom); mode = 8'($urandom);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (q_o[k] !== 4'b1111) begin
                errors++; $display("FAIL rising_edge dut%0d: got %b want 1111", k, q_o[k]);
            end
        end
    endtask

    task automatic test_illegal();
        en = 1'b1; load = 1'b1; load_val = 4'b1111; err_clr = 1'b1;
        tick();
        load = 1'b0; err_clr = 1'b0;
        mode = 8'h00; a = 4'b0001; b = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            int exp_cnt;
            tick();
            exp_cnt = (i + 1 > CMAX) ? CMAX : i + 1;
            checks++;
            if (q_o[0] !== 4'b1111) begin
                errors++; $display("FAIL sr_hold_q edge%0d: got %b want 1111", i, q_o[0]);
            end
            checks++;
            if (q_o[1] !== 4'b1110) begin
                errors++; $display("FAIL sr_force0_q edge%0d: got %b want 1110", i, q_o[1]);
            end
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (ill_o[k] !== 4'b0001 || cnt_o[k] !== 2'(exp_cnt)) begin
                    errors++;
                    $display("FAIL sr_illegal dut%0d edge%0d: got ill=%b cnt=%0d want 0001/%0d",
                             k, i, ill_o[k], cnt_o[k], exp_cnt);
                end
            end
        end
    endtask

    task automatic test_clear();
        mode = 8'h00; en = 1'b1; err_clr = 1'b1; a = 4'b0100; b = 4'b0100;
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (ill_o[k] !== 4'b0100 || cnt_o[k] !== 2'd1) begin
                errors++; $display("FAIL clr_collide dut%0d: got ill=%b cnt=%0d want 0100/1", k, ill_o[k], cnt_o[k]);
            end
        end
        a = 4'b0000; b = 4'b0000;
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (ill_o[k] !== 4'b0000 || cnt_o[k] !== 2'd0) begin
                errors++; $display("FAIL clr_plain dut%0d: got ill=%b cnt=%0d want 0000/0", k, ill_o[k], cnt_o[k]);
            end
            checks++;
            if (q_o[k] !== m_q[k]) begin
                errors++; $display("FAIL clr_q dut%0d: got %b want %b", k, q_o[k], m_q[k]);
            end
        end
        err_clr = 1'b0;
    endtask

    task automatic test_priority();
        en = 1'b0; load = 1'b1; load_val = 4'b1010; mode = 8'h00; a = 4'b1111; b = 4'b1111;
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (q_o[k] !== 4'b1010 || ill_o[k] !== 4'b0000 || cnt_o[k] !== 2'd0) begin
                errors++;
                $display("FAIL prio_load dut%0d: got q=%b ill=%b cnt=%0d want 1010/0000/0",
                         k, q_o[k], ill_o[k], cnt_o[k]);
            end
        end
        load = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a = 4'($urandom); b = 4'($urandom); mode = 8'($urandom);
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (q_o[k] !== 4'b1010 || cnt_o[k] !== 2'd0) begin
                    errors++; $display("FAIL prio_hold dut%0d: got q=%b cnt=%0d want 1010/0", k, q_o[k], cnt_o[k]);
                end
            end
        end
    endtask

    task automatic test_jk_toggle();
        en = 1'b1; load = 1'b1; load_val = 4'b0000;
        tick();
        load = 1'b0; mode = 8'h55; a = 4'b1111; b = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            logic [3:0] exp_q;
            tick();
            exp_q = (i % 2 == 0) ? 4'b1111 : 4'b0000;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (q_o[k] !== exp_q || qb_o[k] !== ~exp_q) begin
                    errors++;
                    $display("FAIL jk_toggle dut%0d edge%0d: got q=%b qbar=%b want %b/%b",
                             k, i, q_o[k], qb_o[k], exp_q, ~exp_q);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            mode     = 8'($urandom);
            a        = 4'($urandom);
            b        = 4'($urandom);
            load_val = 4'($urandom);
            en       = ($urandom_range(0, 7) != 0);
            load     = ($urandom_range(0, 7) == 0);
            err_clr  = ($urandom_range(0, 9) == 0);
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (q_o[k] !== m_q[k] || qb_o[k] !== ~m_q[k]) begin
                    errors++;
                    $display("FAIL rnd_q dut%0d step%0d: got q=%b qbar=%b want %b", k, n, q_o[k], qb_o[k], m_q[k]);
                end
                checks++;
                if (ill_o[k] !== m_ill[k] || cnt_o[k] !== 2'(m_cnt[k])) begin
                    errors++;
                    $display("FAIL rnd_err dut%0d step%0d: got ill=%b cnt=%0d want %b/%0d",
                             k, n, ill_o[k], cnt_o[k], m_ill[k], m_cnt[k]);
                end
            end
        end
        en = 1'b0; load = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mixed();
        test_illegal();
        test_clear();
        test_priority();
        test_jk_toggle();
        test_random();
        test_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ff_bank

`default_nettype wire
